// File: rtl/msrh_pkg.sv
// Shared rename-stage sizing constants and free-list pointer type.
package msrh_pkg;

    localparam int unsigned RNID_W       = 7;
    localparam int unsigned DISP_SIZE    = 5;
    localparam int unsigned CMT_BUS_SIZE = 4;
    localparam int unsigned FLIST_SIZE   = 32;
    localparam int unsigned FLIST_PTR_W  = $clog2(FLIST_SIZE) + 1;

    typedef logic [FLIST_PTR_W-1:0] flist_ptr_t;

endpackage

// File: rtl/msrh_prefix_cnt.sv
// Exclusive prefix popcount of a request vector, plus the total set-bit count.
module msrh_prefix_cnt #(
    parameter int unsigned N = 4,
    parameter int unsigned W = $clog2(N + 1)
) (
    input  logic [N-1:0]        bits_i,
    output logic [N-1:0][W-1:0] prefix_o,
    output logic [W-1:0]        total_o
);

    logic [W-1:0] acc;

    always_comb begin
        acc = '0;
        for (int unsigned k = 0; k < N; k++) begin
            prefix_o[k] = acc;
            acc         = acc + W'(bits_i[k]);
        end
        total_o = acc;
    end

endmodule

// File: rtl/msrh_freelist_mp.sv
// Multi-port RNID free list: compacted pops and pushes on a circular buffer.
// Define MSRH_FREELIST_FLUSH_EN to add commit tracking and flush rewind of the head.
module msrh_freelist_mp
    import msrh_pkg::*;
#(
    parameter int unsigned SIZE       = 32,
    parameter int unsigned WIDTH      = RNID_W,
    parameter int unsigned POP_PORTS  = DISP_SIZE,
    parameter int unsigned PUSH_PORTS = CMT_BUS_SIZE,
    parameter int unsigned INIT_BASE  = 0,
    localparam int unsigned IDX_W     = $clog2(SIZE),
    localparam int unsigned PTR_W     = IDX_W + 1
) (
    input  logic                             i_clk,
    input  logic                             i_reset,
    input  logic [POP_PORTS-1:0]             i_pop_valid,
    output logic                             o_pop_ready,
    output logic [POP_PORTS-1:0][WIDTH-1:0]  o_pop_rnid,
    input  logic [PUSH_PORTS-1:0]            i_push_valid,
    input  logic [PUSH_PORTS-1:0][WIDTH-1:0] i_push_rnid,
    output logic [PTR_W-1:0]                 o_count
`ifdef MSRH_FREELIST_FLUSH_EN
    ,
    input  logic [$clog2(POP_PORTS):0]       i_cmt_cnt,
    input  logic                             i_flush
`endif
);

    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d, count;
    logic [WIDTH-1:0] mem_q [SIZE];

    logic [POP_PORTS-1:0][PTR_W-1:0]  pop_prefix;
    logic [PUSH_PORTS-1:0][PTR_W-1:0] push_prefix;
    logic [PTR_W-1:0]                 n_pop, n_push;
    logic                             flush, pop_accept;

    msrh_prefix_cnt #(.N(POP_PORTS), .W(PTR_W)) u_pop_cnt (
        .bits_i   (i_pop_valid),
        .prefix_o (pop_prefix),
        .total_o  (n_pop)
    );

    msrh_prefix_cnt #(.N(PUSH_PORTS), .W(PTR_W)) u_push_cnt (
        .bits_i   (i_push_valid),
        .prefix_o (push_prefix),
        .total_o  (n_push)
    );

`ifdef MSRH_FREELIST_FLUSH_EN
    logic [PTR_W-1:0] cmt_head_q, cmt_head_d;
    assign flush = i_flush;
`else
    assign flush = 1'b0;
`endif

    // Pushes this cycle are not counted, so same-cycle IDs are never handed out.
    assign count       = tail_q - head_q;
    assign o_count     = count;
    assign o_pop_ready = (count >= n_pop) && !flush;
    assign pop_accept  = (|i_pop_valid) && o_pop_ready;

    always_comb begin
        for (int unsigned k = 0; k < POP_PORTS; k++) begin
            o_pop_rnid[k] = mem_q[IDX_W'(head_q + pop_prefix[k])];
        end
    end

    always_comb begin
        head_d = pop_accept ? head_q + n_pop : head_q;
        tail_d = tail_q + n_push;
`ifdef MSRH_FREELIST_FLUSH_EN
        cmt_head_d = cmt_head_q + PTR_W'(i_cmt_cnt);
        if (i_flush) begin
            head_d = cmt_head_d;
        end
`endif
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            head_q <= '0;
            tail_q <= PTR_W'(SIZE);
            for (int unsigned i = 0; i < SIZE; i++) begin
                mem_q[i] <= WIDTH'(INIT_BASE + i);
            end
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            for (int unsigned j = 0; j < PUSH_PORTS; j++) begin
                if (i_push_valid[j]) begin
                    mem_q[IDX_W'(tail_q + push_prefix[j])] <= i_push_rnid[j];
                end
            end
        end
    end

`ifdef MSRH_FREELIST_FLUSH_EN
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cmt_head_q <= '0;
        end else begin
            cmt_head_q <= cmt_head_d;
        end
    end

    a_cmt_range: assert property (@(posedge i_clk) disable iff (i_reset)
        PTR_W'(i_cmt_cnt) <= head_q - cmt_head_q);
`endif

    a_push_overflow: assert property (@(posedge i_clk) disable iff (i_reset)
        n_push <= PTR_W'(SIZE) - count);

endmodule

// File: tb/tb_msrh_freelist_mp.sv
// Self-checking bench for msrh_freelist_mp: directed table, corner sequences, random vs queue model.
module tb_msrh_freelist_mp;
    import msrh_pkg::*;

    localparam int unsigned SIZE  = 32;
    localparam int unsigned WIDTH = RNID_W;
    localparam int unsigned NP    = DISP_SIZE;
    localparam int unsigned NU    = CMT_BUS_SIZE;
    localparam int unsigned PTR_W = $clog2(SIZE) + 1;

    typedef logic [NP-1:0][WIDTH-1:0] rn_t;
    typedef logic [NU-1:0][WIDTH-1:0] ids_t;

    typedef struct packed {
        logic [NP-1:0]    pv;
        logic             rdy;
        rn_t              r;
        logic [PTR_W-1:0] cnt;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [NP-1:0]    pop_v = '0;
    logic             pop_ready;
    rn_t              pop_rnid;
    logic [NU-1:0]    push_v = '0;
    ids_t             push_rnid = '0;
    logic [PTR_W-1:0] count;
`ifdef MSRH_FREELIST_FLUSH_EN
    logic [$clog2(NP):0] cmt_cnt = '0;
    logic                flush = 1'b0;
`endif

    always #5 clk = ~clk;

    msrh_freelist_mp #(
        .SIZE(SIZE), .WIDTH(WIDTH), .POP_PORTS(NP), .PUSH_PORTS(NU), .INIT_BASE(0)
    ) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_pop_valid  (pop_v),
        .o_pop_ready  (pop_ready),
        .o_pop_rnid   (pop_rnid),
        .i_push_valid (push_v),
        .i_push_rnid  (push_rnid),
        .o_count      (count)
`ifdef MSRH_FREELIST_FLUSH_EN
        ,
        .i_cmt_cnt    (cmt_cnt),
        .i_flush      (flush)
`endif
    );

    int nvec = 0;
    int nerr = 0;
    int q[$];  // free RNIDs in allocation order

    task automatic check(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        for (int i = 0; i < int'(SIZE); i++) q.push_back(i);
    endtask

    task automatic do_reset();
        rst = 1'b1; pop_v = '0; push_v = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        check("reset_count", int'(count), SIZE);
        check("reset_ready", int'(pop_ready), 1);
    endtask

    // One cycle checked against the model; returns what the DUT showed.
    task automatic apply(input logic [NP-1:0] pv, input logic [NU-1:0] uv, input ids_t ids,
                         output logic rdy_o, output rn_t rn_o, output logic [PTR_W-1:0] cnt_o);
        int  n, k;
        bit  rdy;
        pop_v = pv; push_v = uv; push_rnid = ids;
        #1;
        rdy_o = pop_ready; rn_o = pop_rnid;
        n   = $countones(pv);
        rdy = (q.size() >= n);
        check("pop_ready", int'(pop_ready), int'(rdy));
        if (rdy && n > 0) begin
            k = 0;
            for (int l = 0; l < int'(NP); l++) begin
                if (pv[l]) begin
                    check($sformatf("lane%0d_rnid", l), int'(pop_rnid[l]), q[k]);
                    k++;
                end
            end
            repeat (n) void'(q.pop_front());
        end
        for (int j = 0; j < int'(NU); j++) if (uv[j]) q.push_back(int'(ids[j]));
        @(posedge clk); #1;
        cnt_o = count;
        check("count", int'(count), q.size());
        pop_v = '0; push_v = '0;
    endtask

    function automatic vec_t mk(input logic [NP-1:0] pv, input logic rdy, input int a, input int b,
                                input int c, input int d, input int e, input int cnt);
        vec_t v;
        v.pv = pv; v.rdy = rdy; v.cnt = PTR_W'(cnt);
        v.r[0] = WIDTH'(a); v.r[1] = WIDTH'(b); v.r[2] = WIDTH'(c);
        v.r[3] = WIDTH'(d); v.r[4] = WIDTH'(e);
        return v;
    endfunction

    function automatic ids_t seq_ids(input int base);
        ids_t t;
        for (int j = 0; j < int'(NU); j++) t[j] = WIDTH'(base + j);
        return t;
    endfunction

    vec_t             tbl[9];
    logic             r_rdy;
    rn_t              r_rn;
    logic [PTR_W-1:0] r_cnt;
    ids_t             ids;

    initial begin
        tbl[0] = mk(5'b11111, 1, 0, 1, 2, 3, 4, 27);
        tbl[1] = mk(5'b10100, 1, 0, 0, 5, 0, 6, 25);
        tbl[2] = mk(5'b11111, 1, 7, 8, 9, 10, 11, 20);
        tbl[3] = mk(5'b11111, 1, 12, 13, 14, 15, 16, 15);
        tbl[4] = mk(5'b11111, 1, 17, 18, 19, 20, 21, 10);
        tbl[5] = mk(5'b11111, 1, 22, 23, 24, 25, 26, 5);
        tbl[6] = mk(5'b00111, 1, 27, 28, 29, 0, 0, 2);
        tbl[7] = mk(5'b00111, 0, 0, 0, 0, 0, 0, 2);
        tbl[8] = mk(5'b00011, 1, 30, 31, 0, 0, 0, 0);

        repeat (2) @(posedge clk);
        #1;
        do_reset();

        for (int i = 0; i < 9; i++) begin
            apply(tbl[i].pv, '0, '0, r_rdy, r_rn, r_cnt);
            check($sformatf("tbl%0d_ready", i), int'(r_rdy), int'(tbl[i].rdy));
            check($sformatf("tbl%0d_count", i), int'(r_cnt), int'(tbl[i].cnt));
            for (int l = 0; l < int'(NP); l++) begin
                if (tbl[i].pv[l] && tbl[i].rdy)
                    check($sformatf("tbl%0d_lane%0d", i, l), int'(r_rn[l]), int'(tbl[i].r[l]));
            end
        end

        // Wrap: advance tail to index 30, drain, then push across the boundary.
        for (int i = 0; i < 7; i++) apply('0, 4'b1111, seq_ids(40 + 4 * i), r_rdy, r_rn, r_cnt);
        apply('0, 4'b0011, seq_ids(68), r_rdy, r_rn, r_cnt);
        check("wrap_fill_count", int'(r_cnt), 30);
        repeat (6) apply(5'b11111, '0, '0, r_rdy, r_rn, r_cnt);
        apply('0, 4'b1111, seq_ids(80), r_rdy, r_rn, r_cnt);
        check("wrap_push_count", int'(r_cnt), 4);
        apply(5'b01111, '0, '0, r_rdy, r_rn, r_cnt);
        for (int l = 0; l < 4; l++) check($sformatf("wrap_lane%0d", l), int'(r_rn[l]), 80 + l);
        check("wrap_empty", int'(r_cnt), 0);

        // Same-cycle pop/push: pushed IDs do not count toward this cycle's pop.
        apply('0, 4'b0001, seq_ids(90), r_rdy, r_rn, r_cnt);
        apply(5'b00011, 4'b0111, seq_ids(91), r_rdy, r_rn, r_cnt);
        check("pp_reject_ready", int'(r_rdy), 0);
        check("pp_reject_count", int'(r_cnt), 4);
        apply(5'b00011, '0, '0, r_rdy, r_rn, r_cnt);
        apply(5'b00011, 4'b0111, seq_ids(94), r_rdy, r_rn, r_cnt);
        check("pp_accept_ready", int'(r_rdy), 1);
        check("pp_accept_lane0", int'(r_rn[0]), 92);
        check("pp_accept_lane1", int'(r_rn[1]), 93);
        check("pp_accept_count", int'(r_cnt), 3);

        // Mid-operation reset restores the initial contents.
        do_reset();
        apply(5'b11111, '0, '0, r_rdy, r_rn, r_cnt);
        for (int l = 0; l < int'(NP); l++) check($sformatf("rst_lane%0d", l), int'(r_rn[l]), l);

        for (int c = 0; c < 400; c++) begin
            logic [NP-1:0] pv;
            logic [NU-1:0] uv;
            int            free;
            pv   = NP'($urandom);
            uv   = NU'($urandom);
            free = int'(SIZE) - q.size();
            for (int j = int'(NU) - 1; j >= 0; j--) if ($countones(uv) > free) uv[j] = 1'b0;
            for (int j = 0; j < int'(NU); j++) ids[j] = WIDTH'($urandom_range(0, 127));
            apply(pv, uv, ids, r_rdy, r_rn, r_cnt);
        end

`ifdef MSRH_FREELIST_FLUSH_EN
        do_reset();
        apply(5'b11111, '0, '0, r_rdy, r_rn, r_cnt);
        apply(5'b11111, '0, '0, r_rdy, r_rn, r_cnt);
        cmt_cnt = 4;
        apply('0, '0, '0, r_rdy, r_rn, r_cnt);
        cmt_cnt = 2; flush = 1'b1; pop_v = 5'b00001;
        #1;
        check("flush_ready", int'(pop_ready), 0);
        @(posedge clk); #1;
        check("flush_count", int'(count), 26);
        cmt_cnt = '0; flush = 1'b0; pop_v = '0;
        model_reset();
        repeat (6) void'(q.pop_front());
        apply(5'b00001, '0, '0, r_rdy, r_rn, r_cnt);
        check("flush_rewind_rnid", int'(r_rn[0]), 6);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/msrh_freelist_mp.md
# msrh_freelist_mp

Multi-port physical-register free list for the rename stage. It hands out up to `POP_PORTS` RNIDs per cycle to dispatch lanes and accepts up to `PUSH_PORTS` released RNIDs per cycle from commit. It generalises the fixed single-lane free list to parametrised depth, ID width, lane count and base ID. Optionally, it supports flush recovery by rewinding speculative allocations to the committed head.

## Interface
Parameters:
- `SIZE`, 32: number of entries; must be a power of two.
- `WIDTH`, `msrh_pkg::RNID_W`: width of each stored RNID.
- `POP_PORTS`, `msrh_pkg::DISP_SIZE`: allocation lanes.
- `PUSH_PORTS`, `msrh_pkg::CMT_BUS_SIZE`: release lanes.
- `INIT_BASE`, 0: the RNID loaded into entry 0 at reset; entry i gets INIT_BASE+i.

Ports (clock and reset first):
- `i_clk`  in  1  clock.
- `i_reset`  in  1  synchronous active-high reset.
- `i_pop_valid`  in  POP_PORTS  per-lane allocation request; the set bits may be sparse.
- `o_pop_ready`  out  1  high when all requested lanes can be served this cycle.
- `o_pop_rnid`  out  POP_PORTS×WIDTH  RNID for each lane; valid where i_pop_valid is set and o_pop_ready is high.
- `i_push_valid`  in  PUSH_PORTS  per-lane release; the set bits may be sparse.
- `i_push_rnid`  in  PUSH_PORTS×WIDTH  released RNIDs.
- `o_count`  out  $clog2(SIZE)+1  registered number of free entries.
- `i_cmt_cnt`  in  $clog2(POP_PORTS)+1  number of allocations retired this cycle (only with the flush feature).
- `i_flush`  in  1  pipeline flush; rewind speculative allocations (only with the flush feature).

## Operation
- The free list is a circular buffer `mem[SIZE]`.
- It has pointers `head`, `tail` and `cmt_head`, each $clog2(SIZE)+1 bits wide; the MSB is the wrap bit.
- `count = tail - head`, computed modulo 2^(log2 SIZE + 1). `o_count` equals `count`.
- Pop is all-or-nothing:
  - n_pop = popcount(i_pop_valid).
  - o_pop_ready = (count ≥ n_pop) && !i_flush.
- Lane k receives mem[(head + prefix_pop(k)) mod SIZE]. prefix_pop(k) is the number of set i_pop_valid bits below k. Lanes without a request output don't-care.
- A pop is accepted when i_pop_valid≠0 and o_pop_ready=1. On acceptance, head advances by n_pop.
- Push writes are compacted: push lane j writes mem[(tail + prefix_push(j)) mod SIZE], and tail advances by popcount(i_push_valid).
- RNIDs pushed in a cycle cannot be popped in the same cycle. o_pop_ready uses the registered count.
- Pushing more than SIZE−count entries is illegal; an assertion checks this.
- Wrap-around: the index is the low log2(SIZE) bits of a pointer, and the wrap bit toggles on overflow. count = SIZE (full) and count = 0 (empty) are both representable.
- Reset (at any time, including mid-operation):
  - head=0, tail=SIZE (wrap bit set, index 0), cmt_head=0.
  - mem[i]=INIT_BASE+i.
  - o_count=SIZE; o_pop_ready=1 when i_pop_valid=0.

## Timing
- Pop: combinational from the registered state, with zero-cycle latency. The head update is visible in the next cycle.
- Push: the write and the tail advance take effect at the next clock edge. The pushed entries become poppable one cycle after the push.
- Simultaneous pop and push: head and tail update independently. count(t+1) = count(t) − n_pop + n_push.
- Flush (feature enabled):
  - In the flush cycle, o_pop_ready is 0 and no pop is accepted.
  - Next cycle: head = cmt_head + i_cmt_cnt.
  - A push and a commit in the same cycle as the flush are both honoured.

## Configuration
- `MSRH_FREELIST_FLUSH_EN` defined:
  - The i_cmt_cnt and i_flush ports exist.
  - cmt_head advances by i_cmt_cnt each cycle. i_cmt_cnt must not exceed head − cmt_head.
  - The flush rewind described above applies.
- Undefined:
  - The ports and cmt_head are absent.
  - head only advances on pop, and there is no recovery.

## Structure
- Add to msrh_pkg:
  - `FLIST_PTR_W = $clog2(FLIST_SIZE)+1`.
  - typedef `flist_ptr_t`.
- Sub-module `msrh_prefix_cnt`:
  - Parameter N.
  - Outputs the exclusive prefix popcount of each bit and the total.
  - Instantiated once for the pop lanes and once for the push lanes.

## Test plan
- Reset with SIZE=32, INIT_BASE=0 → o_count=32. A pop with i_pop_valid=5'b11111 returns RNIDs 0,1,2,3,4; next cycle o_count=27.
- Sparse pop, i_pop_valid=5'b10100, after the first test → lane2=5, lane4=6; o_count=25.
- Drain to count=2, then request 3 lanes → o_pop_ready=0, head unchanged. Request 2 lanes → accepted; o_count=0.
- Wrap-around: push 4 IDs at tail index 30 → they are written to entries 30,31,0,1; the tail wrap bit toggles; a later pop returns them in order.
- Same-cycle pop 2 / push 3 at count=1 → the pop is rejected (1<2). With count=2, the pop is accepted; next-cycle o_count=3.
- Flush (feature on): allocate 10, commit 4, flush with i_cmt_cnt=2 → next-cycle head=6 and o_count rises by 4. Assert reset mid-sequence → o_count=32 and mem is reinitialised.
